mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single-port synchronous data memory between the control logic (port A) and a second master (port B, e.g. a debug/DMA loader).
- Sits between the requesters and data_mem. Owns the data memory address, write data and write enable.
- Returns read data with a valid strobe.
- Round-robin arbitration; one access in flight at a time.

Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- LOCK_MAX, 4, max consecutive locked grants (optional feature only)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- a_req  in  1  port A request; held with a_we/a_addr/a_wdata stable until a_gnt
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_gnt  out  1  one-cycle pulse: port A access issued to memory
- a_rvalid  out  1  one-cycle pulse: a_rdata valid
- a_rdata  out  DATA_W  port A read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: identical to port A, for port B
- mem_addr  out  ADDR_W  to data_mem addra
- mem_din  out  DATA_W  to data_mem dina
- mem_we  out  1  to data_mem wea
- mem_dout  in  DATA_W  from data_mem douta (1-cycle synchronous read latency)

Behaviour:
- Reset (rst=0, async): state=IDLE; last_grant=B so A wins the first tie.
- Reset values: all gnt/rvalid/mem_we=0; mem_addr, mem_din, rdata=0.
- FSM IDLE:
  - No request: remain in IDLE.
  - Any request: pick a winner.
    - Single requester wins.
    - Both requesting: the port that is not last_grant wins.
  - Register the winner's we/addr/wdata, update last_grant, go to ACCESS.
- FSM ACCESS (1 cycle):
  - mem_addr/mem_din driven from the captured values.
  - mem_we = captured we.
  - Winner's gnt=1.
  - Next state: write → IDLE; read → RESP.
- FSM RESP (1 cycle):
  - Winner's rvalid=1, rdata=mem_dout.
  - Next state → IDLE.
- Latency from req sampled in IDLE:
  - gnt appears 1 cycle later.
  - Read rvalid appears 2 cycles later.
  - Throughput: write 2 cycles per access, read 3 cycles per access.
- Handshake:
  - Requester deasserts req on the cycle after gnt, or keeps it high to request again.
  - A req still high in IDLE is a new request.
  - Changes to req, addr or data of a non-granted port have no effect until that port wins.
- mem_we is 1 only in ACCESS with a write; never 1 in IDLE or RESP.
- rdata holds its last value outside RESP; only the winner's rdata updates.
- Simultaneous requests every cycle: grants strictly alternate A, B, A, B...
- A request arriving during ACCESS/RESP waits; it is evaluated in the next IDLE.
- Reset mid-access: FSM aborts to IDLE immediately. mem_we drops asynchronously; no gnt or rvalid is emitted for the aborted access.

Optional Feature:
- Macro MEM_ARBITER_LOCK_EN.
- With the macro: adds inputs a_lock and b_lock (1 bit each).
  - If the winner's lock is high when its access completes, the next arbitration considers only that port, while it requests and lock stays high.
  - The lock is capped at LOCK_MAX consecutive grants. After that, the other port wins if requesting.
  - The consecutive-grant counter clears on reset, on a grant to the other port, or when lock is low.
- Without the macro: no lock ports; pure round-robin.

Decomposition:
- Package mem_arbiter_pkg: state enum (IDLE, ACCESS, RESP), port-id constants PORT_A/PORT_B, default ADDR_W/DATA_W.
- Sub-module rr_pick2: combinational 2-way round-robin picker.
  - Inputs: req_a, req_b, last.
  - Outputs: grant_valid, grant_id.
  - Lock override is applied in the parent.

Test Plan:
- Reset then a_req read addr 0x10 (mem holds 0x5A) → a_gnt at +1 cycle, a_rvalid at +2 cycles with a_rdata=0x5A; b outputs stay 0.
- b_req write addr 0x20 data 0xC3 → mem_we=1 for exactly 1 cycle with mem_addr=0x20, mem_din=0xC3, b_gnt same cycle, no b_rvalid.
- a_req and b_req both held high, reads → grant order A, B, A, B over 4 accesses, each 3 cycles apart.
- b_req raised while an A read is in RESP → B granted on the first ACCESS after IDLE; A's rdata is not corrupted.
- Assert rst=0 during ACCESS of a write → mem_we falls without a clock edge; after release state=IDLE; next tie grants A.
- (MEM_ARBITER_LOCK_EN, LOCK_MAX=4) a_lock=1 with both requesting continuously → A granted 4 consecutive times, then B; with a_lock=0 → strict alternation.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Pure declarations: no latency, no flow control.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  function automatic logic other_port(input logic p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the port that was not granted last wins.
// Zero latency; no backpressure (grant_valid simply follows the request inputs).
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = PORT_A;
    if (req_a && req_b) begin
      grant_id = other_port(last);
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for one single-port sync memory: gnt 1 cycle after req, read rvalid 2 cycles after.
// One access in flight; losers hold req until gnt. Optional grant lock: define MEM_ARBITER_LOCK_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef MEM_ARBITER_LOCK_EN
  input  logic              a_lock,
  input  logic              b_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_CAP = CNT_W'(LOCK_MAX);

  state_t            state_q, state_d;
  logic              last_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic [CNT_W-1:0]  lock_cnt_q;

  logic a_lock_i;
  logic b_lock_i;
  logic pick_vld;
  logic pick_id;
  logic lock_hold;
  logic win_id;
  logic win_lock;
  logic done;

`ifdef MEM_ARBITER_LOCK_EN
  assign a_lock_i = a_lock;
  assign b_lock_i = b_lock;
`else
  // Locks tied off so the default build is plain round-robin.
  assign a_lock_i = 1'b0;
  assign b_lock_i = 1'b0;
`endif

  rr_pick2 u_pick (
    .req_a       (a_req),
    .req_b       (b_req),
    .last        (last_q),
    .grant_valid (pick_vld),
    .grant_id    (pick_id)
  );

  // A nonzero counter means the previous winner finished with its lock held.
  always_comb begin
    lock_hold = 1'b0;
    if (lock_cnt_q != '0 && lock_cnt_q < LOCK_CAP) begin
      lock_hold = (last_q == PORT_A) ? (a_req & a_lock_i) : (b_req & b_lock_i);
    end
    win_id   = lock_hold ? last_q : pick_id;
    win_lock = (win_q == PORT_A) ? a_lock_i : b_lock_i;
    done     = (state_q == ACCESS && we_q) || (state_q == RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = ACCESS;
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= PORT_B;
      win_q      <= PORT_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      lock_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && pick_vld) begin
        win_q   <= win_id;
        last_q  <= win_id;
        we_q    <= (win_id == PORT_A) ? a_we    : b_we;
        addr_q  <= (win_id == PORT_A) ? a_addr  : b_addr;
        wdata_q <= (win_id == PORT_A) ? a_wdata : b_wdata;
        if (win_id != last_q) lock_cnt_q <= '0;
      end
      if (done) begin
        if (!win_lock) begin
          lock_cnt_q <= '0;
        end else if (lock_cnt_q != LOCK_CAP) begin
          lock_cnt_q <= lock_cnt_q + 1'b1;
        end
      end
      if (state_q == RESP) begin
        if (win_q == PORT_A) a_rdata_q <= mem_dout;
        else                 b_rdata_q <= mem_dout;
      end
    end
  end

  // Strobes decode straight from state so an async reset kills them at once.
  always_comb begin
    mem_addr = addr_q;
    mem_din  = wdata_q;
    mem_we   = (state_q == ACCESS) && we_q;
    a_gnt    = (state_q == ACCESS) && (win_q == PORT_A);
    b_gnt    = (state_q == ACCESS) && (win_q == PORT_B);
    a_rvalid = (state_q == RESP) && (win_q == PORT_A);
    b_rvalid = (state_q == RESP) && (win_q == PORT_B);
    a_rdata  = a_rvalid ? mem_dout : a_rdata_q;
    b_rdata  = b_rvalid ? mem_dout : b_rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural data memory and a grant/read scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic       a_req, a_we, a_gnt, a_rvalid;
  logic [7:0] a_addr, a_wdata, a_rdata;
  logic       b_req, b_we, b_gnt, b_rvalid;
  logic [7:0] b_addr, b_wdata, b_rdata;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic       mem_we;
`ifdef MEM_ARBITER_LOCK_EN
  logic       a_lock, b_lock;
`endif

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .a_rvalid (a_rvalid),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .b_rvalid (b_rvalid),
    .b_rdata  (b_rdata),
`ifdef MEM_ARBITER_LOCK_EN
    .a_lock   (a_lock),
    .b_lock   (b_lock),
`endif
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    case (i)
      'h10:    return 8'h5A;
      'h40:    return 8'h77;
      'h41:    return 8'h88;
      default: return 8'(i) ^ 8'h3C;
    endcase
  endfunction

  // Behavioural single-port memory, one-cycle read latency.
  logic       preload;
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;
  typedef struct {
    logic       port;
    logic [7:0] data;
  } rd_t;

  acc_t       gq[$];
  rd_t        rq[$];
  logic [7:0] shadow [256];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_acc(input logic port, input logic we, input logic [7:0] addr,
                            input logic [7:0] data);
    acc_t e;
    if (we) shadow[addr] = data;
    e.port = port;
    e.we   = we;
    e.addr = addr;
    e.data = we ? data : shadow[addr];
    gq.push_back(e);
  endtask

  // Scoreboard: every grant and every read return must match the queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("we_outside_access", 32'(mem_we & ~(a_gnt | b_gnt)), 32'd0);
      if (a_gnt || b_gnt) begin
        chk("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
        chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
        if (gq.size() != 0) begin
          acc_t e;
          e = gq.pop_front();
          chk("gnt_port", 32'(b_gnt), 32'(e.port));
          chk("gnt_we", 32'(mem_we), 32'(e.we));
          chk("gnt_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) chk("gnt_din", 32'(mem_din), 32'(e.data));
          else      rq.push_back('{port: e.port, data: e.data});
        end
      end
      if (a_rvalid || b_rvalid) begin
        chk("rvalid_onehot", 32'(a_rvalid & b_rvalid), 32'd0);
        chk("rvalid_expected", 32'(rq.size() != 0), 32'd1);
        if (rq.size() != 0) begin
          rd_t r;
          r = rq.pop_front();
          chk("rvalid_port", 32'(b_rvalid), 32'(r.port));
          chk("rdata", 32'(b_rvalid ? b_rdata : a_rdata), 32'(r.data));
        end
      end
    end
  end

  // Collects n grants with both requests held; grants must be 3 cycles apart (reads).
  task automatic run_grants(input int n, output logic [7:0] order, output int ngr);
    int cyc = 0;
    int prev = 0;
    order = '0;
    ngr   = 0;
    while (ngr < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_gnt || b_gnt) begin
        order[ngr] = b_gnt;
        if (ngr > 0) chk("grant_gap", 32'(cyc - prev), 32'd3);
        prev = cyc;
        ngr++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] order;
  int         ngr;

  initial begin
    rst = 1'b0; preload = 1'b1;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
`ifdef MEM_ARBITER_LOCK_EN
    a_lock = 0; b_lock = 0;
`endif
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1 preload = 1'b0;
    @(negedge clk);
    chk("rst_strobes", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    rst = 1'b1;

    // A read: gnt at +1, rvalid at +2, B untouched.
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 8'h10;
    expect_acc(PORT_A, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("t1_gnt", 32'(a_gnt), 32'd1);
    a_req = 0;
    @(negedge clk);
    chk("t1_rvalid", 32'(a_rvalid), 32'd1);
    chk("t1_rdata", 32'(a_rdata), 32'h5A);
    chk("t1_b_quiet", 32'({b_gnt, b_rvalid, b_rdata}), 32'd0);
    @(negedge clk);
    chk("t1_rvalid_pulse", 32'(a_rvalid), 32'd0);
    chk("t1_rdata_hold", 32'(a_rdata), 32'h5A);

    // B write: one-cycle mem_we with captured address/data, no rvalid.
    b_req = 1; b_we = 1; b_addr = 8'h20; b_wdata = 8'hC3;
    expect_acc(PORT_B, 1'b1, 8'h20, 8'hC3);
    @(negedge clk);
    chk("t2_gnt", 32'(b_gnt), 32'd1);
    chk("t2_we", 32'(mem_we), 32'd1);
    chk("t2_addr", 32'(mem_addr), 32'h20);
    chk("t2_din", 32'(mem_din), 32'hC3);
    b_req = 0; b_we = 0;
    @(negedge clk);
    chk("t2_we_drop", 32'(mem_we), 32'd0);
    chk("t2_no_rvalid", 32'(b_rvalid), 32'd0);
    b_req = 1; b_addr = 8'h20;
    expect_acc(PORT_B, 1'b0, 8'h20, 8'h00);
    @(negedge clk);
    b_req = 0;
    repeat (2) @(negedge clk);

    // Both requesting reads: strict A,B,A,B.
    a_req = 1; a_addr = 8'h30; b_req = 1; b_addr = 8'h31;
    expect_acc(PORT_A, 1'b0, 8'h30, 8'h00);
    expect_acc(PORT_B, 1'b0, 8'h31, 8'h00);
    expect_acc(PORT_A, 1'b0, 8'h30, 8'h00);
    expect_acc(PORT_B, 1'b0, 8'h31, 8'h00);
    run_grants(4, order, ngr);
    chk("t3_count", 32'(ngr), 32'd4);
    chk("t3_order", 32'(order), 32'h0A);

    // B arrives during A's RESP: waits for IDLE, A's rdata untouched.
    a_req = 1; a_addr = 8'h40;
    expect_acc(PORT_A, 1'b0, 8'h40, 8'h00);
    @(negedge clk);
    chk("t4_a_gnt", 32'(a_gnt), 32'd1);
    a_req = 0;
    @(negedge clk);
    chk("t4_a_rvalid", 32'(a_rvalid), 32'd1);
    b_req = 1; b_addr = 8'h41;
    expect_acc(PORT_B, 1'b0, 8'h41, 8'h00);
    @(negedge clk);
    chk("t4_b_wait", 32'(b_gnt), 32'd0);
    @(negedge clk);
    chk("t4_b_gnt", 32'(b_gnt), 32'd1);
    b_req = 0;
    @(negedge clk);
    chk("t4_b_rdata", 32'(b_rdata), 32'h88);
    chk("t4_a_rdata", 32'(a_rdata), 32'h77);

    // Reset in the ACCESS cycle of a write: mem_we drops without a clock edge.
    @(negedge clk);
    a_req = 1; a_we = 1; a_addr = 8'h50; a_wdata = 8'hEE;
    @(posedge clk);
    #1 chk("t5_we_before", 32'(mem_we), 32'd1);
    #1 rst = 1'b0;
    #1 chk("t5_we_async", 32'(mem_we), 32'd0);
    chk("t5_gnt_async", 32'(a_gnt), 32'd0);
    a_req = 0; a_we = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_idle", 32'({a_gnt, b_gnt, a_rvalid, b_rvalid, mem_we}), 32'd0);
    chk("t5_rdata_reset", 32'(a_rdata), 32'd0);
    a_req = 1; a_addr = 8'h50; b_req = 1; b_addr = 8'h51;
    expect_acc(PORT_A, 1'b0, 8'h50, 8'h00);
    @(negedge clk);
    chk("t5_tie_a", 32'({a_gnt, b_gnt}), 32'b10);
    a_req = 0; b_req = 0;
    repeat (2) @(negedge clk);

`ifdef MEM_ARBITER_LOCK_EN
    // A locked: after B's tie win, A takes 4 grants in a row, then B.
    a_lock = 1;
    a_req = 1; a_addr = 8'h60; b_req = 1; b_addr = 8'h61;
    expect_acc(PORT_B, 1'b0, 8'h61, 8'h00);
    for (int k = 0; k < 4; k++) expect_acc(PORT_A, 1'b0, 8'h60, 8'h00);
    expect_acc(PORT_B, 1'b0, 8'h61, 8'h00);
    run_grants(6, order, ngr);
    chk("lock_count", 32'(ngr), 32'd6);
    chk("lock_order", 32'(order), 32'h21);
    a_lock = 0;
    a_req = 1; b_req = 1;
    expect_acc(PORT_A, 1'b0, 8'h60, 8'h00);
    expect_acc(PORT_B, 1'b0, 8'h61, 8'h00);
    expect_acc(PORT_A, 1'b0, 8'h60, 8'h00);
    expect_acc(PORT_B, 1'b0, 8'h61, 8'h00);
    run_grants(4, order, ngr);
    chk("unlock_order", 32'(order), 32'h0A);
`endif

    repeat (3) @(negedge clk);
    chk("gq_drained", 32'(gq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
